// File: rtl/usb_sie_tx.sv
// USB 2.0 FS SIE transmit path: turns a PID/length request plus a payload stream
// into the UTMI byte sequence PID, payload, CRC16 (data packets), then signals EOP.
module usb_sie_tx #(
    parameter int MAX_LEN = 1023,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             tx_abort,
    input  logic [7:0]       tx_data,
    input  logic             tx_data_valid,
    output logic             tx_data_ready,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_err,
    output logic [7:0]       utmi_data_in,
    output logic             utmi_tx_valid,
    input  logic             utmi_tx_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             vld_q, vld_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc_q, crc_d;
    logic             hs_q, hs_d;
    logic             err_q, err_d;

    logic pid_data, pid_hs, consume, load_slot;

    // Reflected CRC16 (0xA001), one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Data PIDs all end in 2'b11, handshakes in 2'b10.
    assign pid_data  = (tx_pid[1:0] == 2'b11);
    assign pid_hs    = (tx_pid[1:0] == 2'b10);
    assign consume   = vld_q && utmi_tx_ready;
    assign load_slot = consume && !tx_abort && (cnt_q != '0) &&
                       (state_q == S_PID || state_q == S_DATA);

    assign tx_data_ready = load_slot;
    assign tx_busy       = (state_q != S_IDLE);
    assign tx_done       = (state_q == S_EOP);
    assign tx_err        = err_q;
    assign utmi_data_in  = byte_q;
    assign utmi_tx_valid = vld_q;

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        hs_d    = hs_q;
        err_d   = 1'b0;
        if (state_q != S_IDLE && tx_abort) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        if (pid_hs || (pid_data && tx_len <= MAX_LEN_C)) begin
                            state_d = S_PID;
                            byte_d  = {~tx_pid, tx_pid};
                            vld_d   = 1'b1;
                            cnt_d   = pid_hs ? '0 : tx_len;
                            crc_d   = 16'hFFFF;
                            hs_d    = pid_hs;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_PID, S_DATA: begin
                    if (load_slot) begin
                        if (tx_data_valid) begin
                            state_d = S_DATA;
                            byte_d  = tx_data;
                            crc_d   = crc16_byte(crc_q, tx_data);
                            cnt_d   = cnt_q - LEN_W'(1);
                        end else begin
                            // Underrun: drop TxValid so the host sees a truncated packet.
                            state_d = S_IDLE;
                            vld_d   = 1'b0;
                            err_d   = 1'b1;
                        end
                    end else if (consume) begin
                        if (hs_q) begin
                            state_d = S_EOP;
                            vld_d   = 1'b0;
                        end else begin
                            state_d = S_CRC_LO;
                            byte_d  = ~crc_q[7:0];
                        end
                    end
                end
                S_CRC_LO: begin
                    if (consume) begin
                        state_d = S_CRC_HI;
                        byte_d  = ~crc_q[15:8];
                    end
                end
                S_CRC_HI: begin
                    if (consume) begin
                        state_d = S_EOP;
                        vld_d   = 1'b0;
                    end
                end
                S_EOP:   state_d = S_IDLE;
                default: begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            crc_q   <= 16'hFFFF;
            hs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            hs_q    <= hs_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_usb_sie_tx.sv
// Randomized bench for usb_sie_tx: expected UTMI byte streams come from a
// packet-level model (PID byte, payload, CRC16 over a bit list).
module tb_usb_sie_tx;
    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tx_start = 1'b0;
    logic [3:0]       tx_pid = '0;
    logic [LEN_W-1:0] tx_len = '0;
    logic             tx_abort = 1'b0;
    logic [7:0]       tx_data = '0;
    logic             tx_data_valid = 1'b0;
    logic             tx_data_ready, tx_busy, tx_done, tx_err, utmi_tx_valid;
    logic [7:0]       utmi_data_in;
    logic             utmi_tx_ready = 1'b0;

    usb_sie_tx #(.MAX_LEN(1023), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid), .tx_len(tx_len),
        .tx_abort(tx_abort), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_err(tx_err), .utmi_data_in(utmi_data_in), .utmi_tx_valid(utmi_tx_valid),
        .utmi_tx_ready(utmi_tx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] pay [0:1023];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int n_rdy, n_done, n_err, n_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_data_pid(input logic [3:0] p);
        return p inside {4'h3, 4'hB, 4'h7, 4'hF};
    endfunction

    function automatic bit is_hs_pid(input logic [3:0] p);
        return p inside {4'h2, 4'hA, 4'hE, 4'h6};
    endfunction

    // CRC-16/USB: reflected 0xA001, init all-ones, result inverted.
    function automatic logic [15:0] model_crc(input int len);
        bit bits[$];
        logic [15:0] r;
        for (int i = 0; i < len; i++)
            for (int b = 0; b < 8; b++) bits.push_back(pay[i][b]);
        r = 16'hFFFF;
        foreach (bits[k]) r = {1'b0, r[15:1]} ^ ((r[0] ^ bits[k]) ? 16'hA001 : 16'h0000);
        return ~r;
    endfunction

    task automatic build_exp(input logic [3:0] pid, input int len);
        logic [15:0] c;
        exp_q.delete();
        if (!(is_hs_pid(pid) || (is_data_pid(pid) && len <= 1023))) return;
        exp_q.push_back({~pid, pid});
        if (is_data_pid(pid)) begin
            for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
            c = model_crc(len);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
    endtask

    task automatic fill_pay(input int len, input int mode);
        for (int i = 0; i < len; i++) pay[i] = (mode == 0) ? 8'(i) : 8'($urandom);
    endtask

    task automatic run(input logic [3:0] pid, input int len, input int rdy_pct,
                       input int under_idx, input int abort_cyc);
        int idx, cyc;
        bit fin, hold, ab_prev;
        logic [7:0] held;
        idx = 0; cyc = 0; fin = 0; hold = 0; ab_prev = 0; held = '0;
        got.delete();
        n_rdy = 0; n_done = 0; n_err = 0; n_vld = 0;
        @(negedge clk);
        tx_start = 1'b1; tx_pid = pid; tx_len = LEN_W'(len);
        @(posedge clk);
        while (!fin) begin
            @(negedge clk);
            tx_start = 1'b0;
            if (tx_done) n_done++;
            if (tx_err) n_err++;
            if (hold) chk("hold_byte", utmi_data_in, held);
            if (ab_prev) begin
                chk("abort_valid", utmi_tx_valid, 0);
                chk("abort_busy", tx_busy, 0);
            end
            if (tx_done || tx_err || !tx_busy) fin = 1;
            else if (cyc >= 5000) begin
                chk("timeout", 1, 0);
                fin = 1;
            end else begin
                utmi_tx_ready = ($urandom_range(99) < rdy_pct);
                tx_data       = pay[idx];
                tx_data_valid = (idx != under_idx);
                tx_abort      = (cyc == abort_cyc);
                #1;
                if (utmi_tx_valid) n_vld++;
                if (utmi_tx_valid && utmi_tx_ready && !tx_abort) got.push_back(utmi_data_in);
                hold    = utmi_tx_valid && !utmi_tx_ready && !tx_abort;
                held    = utmi_data_in;
                ab_prev = tx_abort;
                if (tx_data_ready && tx_data_valid) begin
                    n_rdy++;
                    idx++;
                end
                @(posedge clk);
                cyc++;
            end
        end
        tx_abort = 1'b0; tx_data_valid = 1'b0; utmi_tx_ready = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input int e_done, input int e_err, input int e_rdy);
        chk({tag, "_nbytes"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
        chk({tag, "_done"}, n_done, e_done);
        chk({tag, "_err"}, n_err, e_err);
        chk({tag, "_rdy"}, n_rdy, e_rdy);
    endtask

    initial begin
        logic [3:0] p;
        int len, full;
        string s;
        #1;
        chk("rst_valid", utmi_tx_valid, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_data", utmi_data_in, 0);
        @(negedge clk);
        rst = 1'b0;

        // ACK
        run(4'h2, 0, 100, -1, -1);
        build_exp(4'h2, 0);
        check_pkt("ack", 1, 0, 0);
        chk("ack_vld_cycles", n_vld, 1);

        // DATA0 zero length
        run(4'h3, 0, 100, -1, -1);
        build_exp(4'h3, 0);
        check_pkt("zlp", 1, 0, 0);

        // DATA1 4 bytes with stalling TxReady
        fill_pay(4, 0);
        run(4'hB, 4, 50, -1, -1);
        build_exp(4'hB, 4);
        check_pkt("data1", 1, 0, 4);

        // Known CRC-16/USB vector "123456789" -> C8 B4
        s = "123456789";
        for (int i = 0; i < 9; i++) pay[i] = s[i];
        run(4'h3, 9, 70, -1, -1);
        exp_q = {8'hC3};
        for (int i = 0; i < 9; i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'hC8);
        exp_q.push_back(8'hB4);
        check_pkt("vec", 1, 0, 9);

        // Rejections
        run(4'h9, 0, 100, -1, -1);
        exp_q.delete();
        check_pkt("bad_pid", 0, 1, 0);
        chk("bad_pid_vld", n_vld, 0);
        chk("bad_pid_busy", tx_busy, 0);
        run(4'h3, 1024, 100, -1, -1);
        check_pkt("bad_len", 0, 1, 0);
        chk("bad_len_busy", tx_busy, 0);

        // Underrun before 2nd byte
        for (int i = 0; i < 3; i++) pay[i] = 8'(i + 1);
        run(4'h3, 3, 100, 1, -1);
        build_exp(4'h3, 3);
        exp_q = exp_q[0:1];
        check_pkt("underrun", 0, 1, 1);
        chk("underrun_vld", utmi_tx_valid, 0);
        run(4'h2, 0, 100, -1, -1);
        build_exp(4'h2, 0);
        check_pkt("ack_after", 1, 0, 0);

        // Abort mid-DATA
        fill_pay(10, 1);
        run(4'h7, 10, 100, -1, 4);
        build_exp(4'h7, 10);
        exp_q = exp_q[0:3];
        check_pkt("abort", 0, 0, 4);

        // Async reset mid-DATA, then a clean packet
        fill_pay(6, 1);
        @(negedge clk);
        tx_start = 1'b1; tx_pid = 4'h3; tx_len = 11'd6;
        tx_data_valid = 1'b1; tx_data = 8'h55; utmi_tx_ready = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", utmi_tx_valid, 0);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_rdy", tx_data_ready, 0);
        chk("mid_rst_data", utmi_data_in, 0);
        tx_data_valid = 1'b0; utmi_tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fill_pay(5, 1);
        run(4'h3, 5, 80, -1, -1);
        build_exp(4'h3, 5);
        check_pkt("post_rst", 1, 0, 5);

        // Random mix
        for (int t = 0; t < 20; t++) begin
            p   = 4'($urandom);
            len = $urandom_range(40);
            fill_pay(len, 1);
            run(p, len, $urandom_range(100, 40), -1, -1);
            build_exp(p, len);
            if (exp_q.size() == 0)    check_pkt($sformatf("rnd%0d", t), 0, 1, 0);
            else if (is_hs_pid(p))    check_pkt($sformatf("rnd%0d", t), 1, 0, 0);
            else                      check_pkt($sformatf("rnd%0d", t), 1, 0, len);
        end

        // Random abort point
        fill_pay(20, 1);
        run(4'hF, 20, 100, -1, $urandom_range(15, 2));
        build_exp(4'hF, 20);
        full = exp_q.size();
        chk("rnd_abort_short", got.size() < full, 1);
        if (got.size() > 0 && got.size() <= full) exp_q = exp_q[0:got.size()-1];
        check_pkt("rnd_abort", 0, 0, got.size());

        // Largest legal payload
        fill_pay(1023, 1);
        run(4'h7, 1023, 100, -1, -1);
        build_exp(4'h7, 1023);
        check_pkt("maxlen", 1, 0, 1023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
